// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//   ID->EX pipeline register for the MIPS-lite core. It captures the decoded
//   control bundle, register operands, register specifiers and the extended
//   immediate on every rising clock edge. It also detects load-use hazards,
//   drives a combinational stall back to fetch/decode, and loads a bubble
//   (an invalid, side-effect-free slot) on a stall or a branch/jump flush.
//
// Parameters:
//   ALU_OP_W  width of the decoder ALUOp field
//   CNT_W     width of the statistics counters
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   id_valid, id_pc                  decode-stage valid flag and PC
//   id_rs_data, id_rt_data           register-file read data
//   id_rs, id_rt, id_rd              register specifiers
//   id_imm16                         raw 16-bit immediate
//   id_<ctrl>, id_aluop              decoder control bits and ALU operation
//   ex_flush                         branch taken / jump redirect this cycle
//   stall                            hold PC and IF/ID (combinational)
//   ex_valid, ex_pc, ex_*_data       registered valid flag and operands
//   ex_imm32                         registered extended immediate
//   ex_rs, ex_rt, ex_rd              registered specifiers
//   ex_<ctrl>, ex_aluop              registered control bits
//   bubble_cnt, flush_cnt            bubble statistics
//
// Configuration macro:
//   STALL_STATS_EN  when defined, bubble_cnt counts hazard bubbles and
//                   flush_cnt counts flush bubbles, both saturating. When
//                   undefined, both ports are tied to zero and no counter
//                   flops exist.
// ----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_pc,
  input  logic [31:0]         id_rs_data,
  input  logic [31:0]         id_rt_data,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  input  logic [15:0]         id_imm16,
  input  logic                id_reg_dst,
  input  logic                id_branch,
  input  logic                id_jmp,
  input  logic                id_write_reg_mux,
  input  logic                id_memread,
  input  logic                id_memwrite,
  input  logic                id_alusrc,
  input  logic                id_regwrite,
  input  logic                id_extend_op,
  input  logic [ALU_OP_W-1:0] id_aluop,
  input  logic                ex_flush,
  output logic                stall,
  output logic                ex_valid,
  output logic [31:0]         ex_pc,
  output logic [31:0]         ex_rs_data,
  output logic [31:0]         ex_rt_data,
  output logic [31:0]         ex_imm32,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd,
  output logic                ex_reg_dst,
  output logic                ex_branch,
  output logic                ex_jmp,
  output logic                ex_write_reg_mux,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_alusrc,
  output logic                ex_regwrite,
  output logic                ex_extend_op,
  output logic [ALU_OP_W-1:0] ex_aluop,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int CTRL_W = 9;

  logic                valid_q,   valid_d;
  logic [31:0]         pc_q,      pc_d;
  logic [31:0]         rsData_q,  rsData_d;
  logic [31:0]         rtData_q,  rtData_d;
  logic [31:0]         imm32_q,   imm32_d;
  logic [4:0]          rs_q,      rs_d;
  logic [4:0]          rt_q,      rt_d;
  logic [4:0]          rd_q,      rd_d;
  logic [CTRL_W-1:0]   ctrl_q,    ctrl_d;
  logic [ALU_OP_W-1:0] aluop_q,   aluop_d;

  logic [CTRL_W-1:0]   idCtrl;
  logic [31:0]         immExt;
  logic                usesRt;
  logic                hazard;

  // Control bits packed in a fixed order so bubbles clear them in one go.
  assign idCtrl = {id_reg_dst, id_branch, id_jmp, id_write_reg_mux, id_memread,
                   id_memwrite, id_alusrc, id_regwrite, id_extend_op};

  assign immExt = id_extend_op ? {{16{id_imm16[15]}}, id_imm16} : {16'b0, id_imm16};

  // rt is a source for R-type ALU ops, stores and branch compares; for
  // immediate ALU ops and loads it is only the destination.
  assign usesRt = ~id_alusrc | id_memwrite | id_branch;

  // Writes to $0 are discarded, so a load into $0 never creates a hazard.
  assign hazard = valid_q & ctrl_q[4] & id_valid & (rt_q != 5'd0) &
                  ((rt_q == id_rs) | (usesRt & (rt_q == id_rt)));

  // A flush discards the dependent instruction anyway, so no stall is needed.
  assign stall = hazard & ~ex_flush;

  // Next-state: a flush or hazard loads an all-zero bubble; otherwise the
  // decode contents are captured with control bits gated by id_valid.
  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    rsData_d = '0;
    rtData_d = '0;
    imm32_d  = '0;
    rs_d     = '0;
    rt_d     = '0;
    rd_d     = '0;
    ctrl_d   = '0;
    aluop_d  = '0;
    if (!ex_flush && !hazard) begin
      valid_d  = id_valid;
      pc_d     = id_pc;
      rsData_d = id_rs_data;
      rtData_d = id_rt_data;
      imm32_d  = immExt;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
      if (id_valid) begin
        ctrl_d  = idCtrl;
        aluop_d = id_aluop;
      end
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rsData_q <= '0;
      rtData_q <= '0;
      imm32_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      aluop_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rsData_q <= rsData_d;
      rtData_q <= rtData_d;
      imm32_q  <= imm32_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      aluop_q  <= aluop_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_rs_data = rsData_q;
  assign ex_rt_data = rtData_q;
  assign ex_imm32   = imm32_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_aluop   = aluop_q;
  assign {ex_reg_dst, ex_branch, ex_jmp, ex_write_reg_mux, ex_memread,
          ex_memwrite, ex_alusrc, ex_regwrite, ex_extend_op} = ctrl_q;

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0] flushCnt_q,  flushCnt_d;

  // Saturating counters; a flush bubble is never also counted as a hazard.
  always_comb begin
    bubbleCnt_d = bubbleCnt_q;
    flushCnt_d  = flushCnt_q;
    if (ex_flush) begin
      if (!(&flushCnt_q)) flushCnt_d = flushCnt_q + 1'b1;
    end else if (hazard) begin
      if (!(&bubbleCnt_q)) bubbleCnt_d = bubbleCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubbleCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      bubbleCnt_q <= bubbleCnt_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

  assign bubble_cnt = bubbleCnt_q;
  assign flush_cnt  = flushCnt_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule
